// File: rtl/fetch_if.sv
// Handshake and memory-side bundle between the fetch sequencer and its environment.
// FETCH_PERF_COUNTERS_EN adds the fetched/stall counter outputs.
interface fetch_if;
    logic        start;
    logic [31:0] program_counter;
    logic [31:0] instruction;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        halted;
    logic        fault;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetched_count;
    logic [31:0] stall_count;
`endif

    modport master (
        input  start, instruction, instr_ready, redirect_valid, redirect_pc,
        output program_counter, instr_out, pc_out, instr_valid, busy, halted, fault
`ifdef FETCH_PERF_COUNTERS_EN
        , output fetched_count, stall_count
`endif
    );

    modport slave (
        output start, instruction, instr_ready, redirect_valid, redirect_pc,
        input  program_counter, instr_out, pc_out, instr_valid, busy, halted, fault
`ifdef FETCH_PERF_COUNTERS_EN
        , input fetched_count, stall_count
`endif
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Drives instruction-memory index, buffers fetched words in a prefetch queue and hands them to decode.
// Optional FETCH_PERF_COUNTERS_EN adds push and full-queue stall counters.
module fetch_sequencer #(
    parameter int unsigned IMEM_DEPTH  = 32,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);
    localparam int unsigned AW       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CW       = AW + 1;
    localparam logic [CW-1:0] FULL   = CW'(QUEUE_DEPTH);
    localparam logic [31:0] LAST_PC  = 32'(IMEM_DEPTH - 1);
    localparam logic [31:0] DEPTH_PC = 32'(IMEM_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HALT} state_t;

    state_t        r_state, w_state_nx;
    logic [31:0]   r_fetch_pc, w_fetch_pc_nx;
    logic [CW-1:0] r_count, w_count_nx;
    logic [AW-1:0] r_rd_ptr, w_rd_ptr_nx;
    logic [AW-1:0] r_wr_ptr, w_wr_ptr_nx;
    logic          r_fault, w_fault_nx;
    logic [31:0]   r_q_instr [QUEUE_DEPTH];
    logic [31:0]   r_q_pc    [QUEUE_DEPTH];

    logic w_pop, w_push, w_redirect, w_halt_word, w_wr_en, w_clear_perf;

    assign w_pop       = (r_count != '0) & bus.instr_ready;
    assign w_halt_word = (bus.instruction == HALT_WORD);
    assign w_push      = (r_state == S_FETCH) & ((r_count < FULL) | w_pop) & ~w_halt_word;
    assign w_redirect  = bus.redirect_valid & ((r_state == S_FETCH) | (r_state == S_DRAIN));

    // Next-state: redirect overrides every same-cycle push/pop
    always_comb begin
        w_state_nx    = r_state;
        w_fetch_pc_nx = r_fetch_pc;
        w_count_nx    = r_count;
        w_rd_ptr_nx   = r_rd_ptr;
        w_wr_ptr_nx   = r_wr_ptr;
        w_fault_nx    = r_fault;
        w_wr_en       = 1'b0;
        w_clear_perf  = 1'b0;

        if (w_redirect) begin
            w_count_nx  = '0;
            w_rd_ptr_nx = '0;
            w_wr_ptr_nx = '0;
            if (bus.redirect_pc < DEPTH_PC) begin
                w_fetch_pc_nx = bus.redirect_pc;
                w_state_nx    = S_FETCH;
            end else begin
                w_state_nx = S_HALT;
                w_fault_nx = 1'b1;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_state_nx    = S_FETCH;
                        w_fetch_pc_nx = RESET_PC;
                        w_clear_perf  = 1'b1;
                    end
                end
                S_HALT: begin
                    if (bus.start) begin
                        w_state_nx    = S_FETCH;
                        w_fetch_pc_nx = RESET_PC;
                        w_fault_nx    = 1'b0;
                        w_count_nx    = '0;
                        w_rd_ptr_nx   = '0;
                        w_wr_ptr_nx   = '0;
                        w_clear_perf  = 1'b1;
                    end
                end
                S_FETCH: begin
                    if (w_pop) w_rd_ptr_nx = r_rd_ptr + AW'(1);
                    if (w_push) begin
                        w_wr_en       = 1'b1;
                        w_wr_ptr_nx   = r_wr_ptr + AW'(1);
                        w_fetch_pc_nx = r_fetch_pc + 32'd1;
                    end
                    if (w_push && !w_pop)      w_count_nx = r_count + CW'(1);
                    else if (!w_push && w_pop) w_count_nx = r_count - CW'(1);
                    // Last legal index ends the program rather than wrapping to 0
                    if (w_halt_word || (w_push && (r_fetch_pc == LAST_PC))) w_state_nx = S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_pop) begin
                        w_rd_ptr_nx = r_rd_ptr + AW'(1);
                        w_count_nx  = r_count - CW'(1);
                    end
                    if ((r_count == '0) || ((r_count == CW'(1)) && w_pop)) w_state_nx = S_HALT;
                end
                default: ;
            endcase
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_fetch_pc <= w_fetch_pc_nx;
            r_count    <= w_count_nx;
            r_rd_ptr   <= w_rd_ptr_nx;
            r_wr_ptr   <= w_wr_ptr_nx;
            r_fault    <= w_fault_nx;
        end
    end

    // Queue storage, tagged with the fetch index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else if (w_wr_en) begin
            r_q_instr[r_wr_ptr] <= bus.instruction;
            r_q_pc[r_wr_ptr]    <= r_fetch_pc;
        end
    end

    assign bus.program_counter = r_fetch_pc;
    assign bus.instr_out       = r_q_instr[r_rd_ptr];
    assign bus.pc_out          = r_q_pc[r_rd_ptr];
    assign bus.instr_valid     = (r_count != '0);
    assign bus.busy            = (r_state == S_FETCH) | (r_state == S_DRAIN);
    assign bus.halted          = (r_state == S_HALT);
    assign bus.fault           = r_fault;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] r_fetched_count;
    logic [31:0] r_stall_count;
    logic        w_stall;

    assign w_stall = (r_state == S_FETCH) & (r_count == FULL) & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetched_count <= '0;
            r_stall_count   <= '0;
        end else if (w_clear_perf) begin
            r_fetched_count <= '0;
            r_stall_count   <= '0;
        end else begin
            if (w_wr_en) r_fetched_count <= r_fetched_count + 32'd1;
            if (w_stall) r_stall_count   <= r_stall_count + 32'd1;
        end
    end

    assign bus.fetched_count = r_fetched_count;
    assign bus.stall_count   = r_stall_count;
`else
    logic w_unused_clear;
    assign w_unused_clear = w_clear_perf;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the fetch/decode contract.
module tb_fetch_sequencer;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned QD    = 4;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
    localparam int M_IDLE = 0, M_FETCHING = 1, M_DRAINING = 2, M_HALTED = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    logic clk;
    logic rst_n;
    fetch_if bus ();

    fetch_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] imem [DEPTH];
    int vecs = 0;
    int errs = 0;

    ent_t        mq[$];
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_fault;
    logic [31:0] m_fetched;
    logic [31:0] m_stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb bus.instruction = (bus.program_counter < 32'(DEPTH)) ? imem[bus.program_counter[4:0]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_at(input logic [31:0] pc);
        return (pc < 32'(DEPTH)) ? imem[pc[4:0]] : 32'h0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_mode    = M_IDLE;
        m_pc      = 32'd0;
        m_fault   = 1'b0;
        m_fetched = 32'd0;
        m_stall   = 32'd0;
    endtask

    // One clock of the fetch contract, applied to the inputs present at the edge
    task automatic model_step();
        bit          pop  = (mq.size() > 0) && bus.instr_ready;
        bit          room = (mq.size() < QD) || pop;
        logic [31:0] w;
        ent_t        e;
        if (m_mode == M_FETCHING && mq.size() == QD && !pop) m_stall++;
        if ((m_mode == M_FETCHING || m_mode == M_DRAINING) && bus.redirect_valid) begin
            mq.delete();
            if (bus.redirect_pc < 32'(DEPTH)) begin
                m_pc   = bus.redirect_pc;
                m_mode = M_FETCHING;
            end else begin
                m_mode  = M_HALTED;
                m_fault = 1'b1;
            end
        end else if ((m_mode == M_IDLE || m_mode == M_HALTED) && bus.start) begin
            mq.delete();
            m_mode    = M_FETCHING;
            m_pc      = 32'd0;
            m_fault   = 1'b0;
            m_fetched = 32'd0;
            m_stall   = 32'd0;
        end else if (m_mode == M_FETCHING) begin
            w = mem_at(m_pc);
            if (pop) void'(mq.pop_front());
            if (w != HALTW && room) begin
                e.pc = m_pc;
                e.w  = w;
                mq.push_back(e);
                m_fetched++;
                if (m_pc == 32'(DEPTH - 1)) m_mode = M_DRAINING;
                m_pc = m_pc + 32'd1;
            end else if (w == HALTW) begin
                m_mode = M_DRAINING;
            end
        end else if (m_mode == M_DRAINING) begin
            if (pop) void'(mq.pop_front());
            if (mq.size() == 0) m_mode = M_HALTED;
        end
    endtask

    task automatic check_all();
        chk("instr_valid", 32'(bus.instr_valid), 32'(mq.size() > 0));
        chk("program_counter", bus.program_counter, m_pc);
        chk("busy", 32'(bus.busy), 32'(m_mode == M_FETCHING || m_mode == M_DRAINING));
        chk("halted", 32'(bus.halted), 32'(m_mode == M_HALTED));
        chk("fault", 32'(bus.fault), 32'(m_fault));
        if (mq.size() > 0) begin
            chk("pc_out", bus.pc_out, mq[0].pc);
            chk("instr_out", bus.instr_out, mq[0].w);
        end
`ifdef FETCH_PERF_COUNTERS_EN
        chk("fetched_count", bus.fetched_count, m_fetched);
        chk("stall_count", bus.stall_count, m_stall);
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        cyc();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        bus.start          = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        for (int i = 0; i < int'(DEPTH); i++) imem[i] = {8'(i), 24'($urandom)};
        for (int i = 0; i < 6; i++) imem[i] = 32'hA000_0000 + 32'(i);
        imem[6] = HALTW;
        model_reset();
        rst_n = 1'b0;
        #23;
        chk("rst program_counter", bus.program_counter, 32'd0);
        chk("rst instr_out", bus.instr_out, 32'd0);
        chk("rst pc_out", bus.pc_out, 32'd0);
        chk("rst instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst halted", 32'(bus.halted), 32'd0);
        chk("rst fault", 32'(bus.fault), 32'd0);
        rst_n = 1'b1;

        // Straight-line program ending on the halt word
        bus.instr_ready = 1'b1;
        pulse_start();
        run(12);
        chk("halt pc", bus.program_counter, 32'd6);
        chk("halt state", 32'(bus.halted), 32'd1);

        // Decode back-pressure fills the queue, then releases it
        bus.instr_ready = 1'b0;
        pulse_start();
        run(9);
        chk("stall pc", bus.program_counter, 32'd4);
        chk("stall head", bus.instr_out, 32'hA000_0000);
        bus.instr_ready = 1'b1;
        run(10);

        // Halt-free image: mid-stream redirect, then run off the end of memory
        imem[6] = {8'd6, 24'h123456};
        pulse_start();
        run(2);
        bus.instr_ready = 1'b0;
        run(4);
        redirect(32'd20);
        chk("flush valid", 32'(bus.instr_valid), 32'd0);
        bus.instr_ready = 1'b1;
        run(5);
        redirect(32'd30);
        run(6);
        chk("end halted", 32'(bus.halted), 32'd1);
        chk("end fault", 32'(bus.fault), 32'd0);
        chk("end pc", bus.program_counter, 32'd32);

        // Out-of-range redirect faults; start recovers
        pulse_start();
        run(3);
        redirect(32'd40);
        chk("oor fault", 32'(bus.fault), 32'd1);
        pulse_start();
        chk("recover fault", 32'(bus.fault), 32'd0);
        run(4);

        // Asynchronous reset between edges while fetching
        cyc();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("arst busy", 32'(bus.busy), 32'd0);
        chk("arst halted", 32'(bus.halted), 32'd0);
        chk("arst program_counter", bus.program_counter, 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
        chk("arst fetched_count", bus.fetched_count, 32'd0);
        chk("arst stall_count", bus.stall_count, 32'd0);
`endif
        #2 rst_n = 1'b1;

        // Randomized traffic with occasional halt words, redirects and restarts
        for (int i = 0; i < int'(DEPTH); i++)
            imem[i] = ($urandom_range(0, 11) == 0) ? HALTW : {8'(i), 24'($urandom)};
        for (int n = 0; n < 600; n++) begin
            bus.instr_ready    = ($urandom_range(0, 9) < 7);
            bus.redirect_valid = ($urandom_range(0, 19) == 0);
            bus.redirect_pc    = 32'($urandom_range(0, 40));
            bus.start          = ($urandom_range(0, 3) == 0);
            cyc();
        end
        bus.start          = 1'b0;
        bus.redirect_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
